// File: rtl/inbuf_frame_sched_pkg.sv
// Shared definitions for the input-frame scheduler: FSM state encoding and frame geometry helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package inbuf_frame_sched_pkg;

    // 3-bit state encoding, shared with cnn_top and the window generator.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_START = 3'd2,
        ST_READ  = 3'd3,
        ST_DONE  = 3'd4
    } sched_state_e;

    // Default frame geometry (480x272 RGB888).
    localparam int unsigned FRAME_WIDTH  = 480;
    localparam int unsigned FRAME_HEIGHT = 272;
    localparam int unsigned FRAME_CNT_W  = 8;

    // A 3x3 window generator emits one valid per interior pixel.
    function automatic int unsigned win_count(input int unsigned w, input int unsigned h);
        return (w - 2) * (h - 2);
    endfunction

endpackage

// File: rtl/inbuf_frame_sched.sv
// Time-shares the single-port input BRAM between the frame loader (writes) and the 3x3 window generator (reads).
// Latency: memory mux is combinational from registered state; BRAM read latency is passed through unchanged.
// Backpressure: oWrReady is high only while loading; loader data offered in any other state is dropped.
//
// Ports:
//   iClk/iRst            clock, asynchronous active-low reset
//   iLoadStart           begin a frame load (honoured only in IDLE, also clears oRdErr)
//   iWrValid/iWrData     loader pixel stream, oWrReady back to the loader
//   oWinStart            one-cycle start to the window generator once the frame is resident
//   iRdCs/iRdAddr        window generator BRAM port, oRdPixel returns iMemDout
//   iWinValid            window generator output valid, counted to detect end of frame
//   oMemEn/oMemWe/oMemAddr/oMemDin/iMemDout   BRAM port A
//   oBusy/oFrameDone/oRdErr/oFrameCnt         status
//
// Optional feature: define FRAME_CNT_EN to get a mod-256 completed-frame counter on oFrameCnt;
// otherwise oFrameCnt is tied to zero and no counter flops exist.
module inbuf_frame_sched
    import inbuf_frame_sched_pkg::*;
#(
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned ADDR_W  = 17,
    parameter int unsigned WIDTH   = FRAME_WIDTH,
    parameter int unsigned HEIGHT  = FRAME_HEIGHT,
    parameter int unsigned DEPTH   = WIDTH * HEIGHT,
    parameter int unsigned WIN_CNT = win_count(WIDTH, HEIGHT)
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iLoadStart,
    input  logic                   iWrValid,
    input  logic [DATA_W-1:0]      iWrData,
    output logic                   oWrReady,
    output logic                   oWinStart,
    input  logic                   iRdCs,
    input  logic [ADDR_W-1:0]      iRdAddr,
    output logic [DATA_W-1:0]      oRdPixel,
    input  logic                   iWinValid,
    output logic                   oMemEn,
    output logic                   oMemWe,
    output logic [ADDR_W-1:0]      oMemAddr,
    output logic [DATA_W-1:0]      oMemDin,
    input  logic [DATA_W-1:0]      iMemDout,
    output logic                   oBusy,
    output logic                   oFrameDone,
    output logic                   oRdErr,
    output logic [FRAME_CNT_W-1:0] oFrameCnt
);

    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] WR_LAST  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] WIN_LAST = ADDR_W'(WIN_CNT - 1);

    sched_state_e      state_q, state_d;
    logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [ADDR_W-1:0] win_cnt_q, win_cnt_d;
    logic              rd_err_q, rd_err_d;

    logic in_idle, in_load, in_start, in_read, in_done;
    logic wr_xfer;

    assign in_idle  = (state_q == ST_IDLE);
    assign in_load  = (state_q == ST_LOAD);
    assign in_start = (state_q == ST_START);
    assign in_read  = (state_q == ST_READ);
    assign in_done  = (state_q == ST_DONE);

    // A loader transfer only happens while ready, so writes cannot leak outside LOAD.
    assign wr_xfer = in_load & iWrValid;

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        wr_cnt_d  = wr_cnt_q;
        win_cnt_d = win_cnt_q;
        rd_err_d  = rd_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (iLoadStart) begin
                    state_d  = ST_LOAD;
                    rd_err_d = 1'b0;
                end
            end
            ST_LOAD: begin
                if (wr_xfer) begin
                    if (wr_cnt_q == WR_LAST) begin
                        state_d  = ST_START;
                        wr_cnt_d = '0;
                    end else begin
                        wr_cnt_d = wr_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_START: begin
                state_d = ST_READ;
            end
            ST_READ: begin
                if (iWinValid) begin
                    if (win_cnt_q == WIN_LAST) begin
                        state_d   = ST_DONE;
                        win_cnt_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + CNT_ONE;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                win_cnt_d = '0;
            end
            default: begin
                state_d   = ST_IDLE;
                wr_cnt_d  = '0;
                win_cnt_d = '0;
            end
        endcase

        // A read request outside READ is a protocol error; it wins over the
        // clear from iLoadStart when both land in the same cycle.
        if (iRdCs && !in_read) begin
            rd_err_d = 1'b1;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state_q   <= ST_IDLE;
            wr_cnt_q  <= '0;
            win_cnt_q <= '0;
            rd_err_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_cnt_q  <= wr_cnt_d;
            win_cnt_q <= win_cnt_d;
            rd_err_q  <= rd_err_d;
        end
    end

    // BRAM port mux: the owner is chosen purely by the registered state.
    always_comb begin
        oMemEn   = 1'b0;
        oMemWe   = 1'b0;
        oMemAddr = '0;
        oMemDin  = '0;
        if (in_load) begin
            oMemEn   = iWrValid;
            oMemWe   = iWrValid;
            oMemAddr = wr_cnt_q;
            oMemDin  = iWrData;
        end else if (in_read) begin
            oMemEn   = iRdCs;
            oMemAddr = iRdAddr;
        end
    end

    assign oWrReady   = in_load;
    assign oWinStart  = in_start;
    assign oFrameDone = in_done;
    assign oBusy      = !in_idle;
    assign oRdErr     = rd_err_q;
    assign oRdPixel   = iMemDout;

`ifdef FRAME_CNT_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            frame_cnt_q <= '0;
        end else if (in_done) begin
            frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
        end
    end

    assign oFrameCnt = frame_cnt_q;
`else
    assign oFrameCnt = '0;
`endif

endmodule

// File: tb/tb_inbuf_frame_sched.sv
module tb_inbuf_frame_sched;

    localparam int DATA_W  = 24;
    localparam int ADDR_W  = 17;
    localparam int WIDTH   = 4;
    localparam int HEIGHT  = 3;
    localparam int DEPTH   = 12;
    localparam int WIN_CNT = 2;

    logic              iClk;
    logic              iRst;
    logic              iLoadStart;
    logic              iWrValid;
    logic [DATA_W-1:0] iWrData;
    logic              oWrReady;
    logic              oWinStart;
    logic              iRdCs;
    logic [ADDR_W-1:0] iRdAddr;
    logic [DATA_W-1:0] oRdPixel;
    logic              iWinValid;
    logic              oMemEn;
    logic              oMemWe;
    logic [ADDR_W-1:0] oMemAddr;
    logic [DATA_W-1:0] oMemDin;
    logic [DATA_W-1:0] iMemDout = '0;
    logic              oBusy;
    logic              oFrameDone;
    logic              oRdErr;
    logic [7:0]        oFrameCnt;

    int checks   = 0;
    int failures = 0;

    inbuf_frame_sched #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WIDTH(WIDTH), .HEIGHT(HEIGHT),
        .DEPTH(DEPTH), .WIN_CNT(WIN_CNT)
    ) dut (
        .iClk(iClk), .iRst(iRst), .iLoadStart(iLoadStart),
        .iWrValid(iWrValid), .iWrData(iWrData), .oWrReady(oWrReady),
        .oWinStart(oWinStart), .iRdCs(iRdCs), .iRdAddr(iRdAddr),
        .oRdPixel(oRdPixel), .iWinValid(iWinValid),
        .oMemEn(oMemEn), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemDin(oMemDin), .iMemDout(iMemDout),
        .oBusy(oBusy), .oFrameDone(oFrameDone), .oRdErr(oRdErr),
        .oFrameCnt(oFrameCnt)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Behavioural single-port BRAM, one-cycle read latency.
    logic [DATA_W-1:0] bram [0:15] = '{default: '0};
    int n_writes = 0;

    always @(posedge iClk) begin
        if (oMemEn) begin
            if (oMemWe) begin
                if (oMemAddr < 16) bram[oMemAddr[3:0]] <= oMemDin;
                n_writes <= n_writes + 1;
            end else if (oMemAddr < 16) begin
                iMemDout <= bram[oMemAddr[3:0]];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: frame phase plus how many pixels / windows have been seen.
    typedef enum {P_IDLE, P_LOAD, P_START, P_READ, P_DONE} phase_t;
    phase_t m_phase  = P_IDLE;
    int     m_loaded = 0;
    int     m_wins   = 0;
    bit     m_err    = 0;
    int     m_frames = 0;
    bit     run_chk  = 1'b1;

    always @(negedge iClk) begin
        if (run_chk) begin
            logic        e_en, e_we;
            logic [31:0] e_addr, e_din, e_cnt;
            if (!iRst) begin
                m_phase = P_IDLE; m_loaded = 0; m_wins = 0; m_err = 0; m_frames = 0;
            end
            e_en   = (m_phase == P_LOAD) ? iWrValid : (m_phase == P_READ) ? iRdCs : 1'b0;
            e_we   = (m_phase == P_LOAD) && iWrValid;
            e_addr = (m_phase == P_LOAD) ? m_loaded : (m_phase == P_READ) ? 32'(iRdAddr) : 0;
            e_din  = (m_phase == P_LOAD) ? 32'(iWrData) : 0;
`ifdef FRAME_CNT_EN
            e_cnt  = m_frames % 256;
`else
            e_cnt  = 0;
`endif
            chk("wr_ready",   32'(oWrReady),   32'(m_phase == P_LOAD));
            chk("win_start",  32'(oWinStart),  32'(m_phase == P_START));
            chk("frame_done", 32'(oFrameDone), 32'(m_phase == P_DONE));
            chk("busy",       32'(oBusy),      32'(m_phase != P_IDLE));
            chk("mem_en",     32'(oMemEn),     32'(e_en));
            chk("mem_we",     32'(oMemWe),     32'(e_we));
            chk("mem_addr",   32'(oMemAddr),   e_addr);
            chk("mem_din",    32'(oMemDin),    e_din);
            chk("rd_err",     32'(oRdErr),     32'(m_err));
            chk("frame_cnt",  32'(oFrameCnt),  e_cnt);
            chk("rd_pixel",   32'(oRdPixel),   32'(iMemDout));

            if (iRst) begin
                if (iRdCs && m_phase != P_READ) m_err = 1;
                else if (m_phase == P_IDLE && iLoadStart) m_err = 0;
                case (m_phase)
                    P_IDLE:  if (iLoadStart) m_phase = P_LOAD;
                    P_LOAD:  if (iWrValid) begin
                                 m_loaded++;
                                 if (m_loaded == DEPTH) begin m_loaded = 0; m_phase = P_START; end
                             end
                    P_START: m_phase = P_READ;
                    P_READ:  if (iWinValid) begin
                                 m_wins++;
                                 if (m_wins == WIN_CNT) begin m_wins = 0; m_phase = P_DONE; end
                             end
                    P_DONE:  begin m_phase = P_IDLE; m_frames++; end
                    default: m_phase = P_IDLE;
                endcase
            end
        end
    end

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic idle_inputs();
        iLoadStart = 0; iWrValid = 0; iWrData = '0; iRdCs = 0; iRdAddr = '0; iWinValid = 0;
    endtask

    // Load one full frame with random gaps, then window it with random read traffic.
    task automatic do_frame(input int base);
        iLoadStart = 1; step(); iLoadStart = 0;
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(0, 2) == 0) begin iWrValid = 0; step(); end
            iWrValid = 1; iWrData = DATA_W'(base + i); step();
        end
        iWrValid = 0; step();
        for (int k = 0; k < WIN_CNT; k++) begin
            while ($urandom_range(0, 1) == 0) begin
                iWinValid = 0; iRdCs = $urandom_range(0, 1);
                iRdAddr = ADDR_W'($urandom_range(0, DEPTH - 1)); step();
            end
            iWinValid = 1; iRdCs = 1; iRdAddr = ADDR_W'($urandom_range(0, DEPTH - 1)); step();
        end
        iWinValid = 0; iRdCs = 0; step();
    endtask

    int wbase;

    initial begin
        idle_inputs();
        iRst = 0;

        // Reset held with random inputs: everything stays quiet.
        repeat (4) begin
            step();
            iLoadStart = $urandom_range(0, 1); iWrValid = $urandom_range(0, 1);
            iWrData = DATA_W'($urandom); iRdCs = $urandom_range(0, 1);
            iRdAddr = ADDR_W'($urandom_range(0, 11)); iWinValid = $urandom_range(0, 1);
            #1;
            chk("rst_busy", 32'(oBusy), 0);
            chk("rst_memen", 32'(oMemEn), 0);
            chk("rst_rderr", 32'(oRdErr), 0);
        end
        idle_inputs();
        iRst = 1;
        repeat (3) step();
        chk("post_rst_busy", 32'(oBusy), 0);

        // Directed load of 0x000100+i.
        wbase = n_writes;
        iLoadStart = 1; step(); iLoadStart = 0;
        chk("load_ready", 32'(oWrReady), 1);
        for (int i = 0; i < DEPTH; i++) begin
            while ($urandom_range(0, 2) == 0) begin iWrValid = 0; step(); end
            iWrValid = 1; iWrData = DATA_W'(32'h100 + i); step();
        end
        // Keep offering data: a 13th pixel must not be written.
        iWrData = 24'hBADBAD;
        chk("start_pulse", 32'(oWinStart), 1);
        chk("start_memen", 32'(oMemEn), 0);
        chk("start_ready", 32'(oWrReady), 0);
        step();
        chk("start_one_cycle", 32'(oWinStart), 0);
        chk("write_count", 32'(n_writes - wbase), 12);
        for (int i = 0; i < DEPTH; i++) chk("bram_content", 32'(bram[i]), 32'h100 + i);

        // Read addr 5 while the loader still pushes.
        iRdCs = 1; iRdAddr = 17'd5; #1;
        chk("read_memen", 32'(oMemEn), 1);
        chk("read_memwe", 32'(oMemWe), 0);
        chk("read_ready", 32'(oWrReady), 0);
        step();
        iRdCs = 0; iWrValid = 0;
        chk("read_pixel", 32'(oRdPixel), 32'h000105);
        iWinValid = 1; step(); iWinValid = 0; step();
        chk("mid_read_done", 32'(oFrameDone), 0);
        iWinValid = 1; step(); iWinValid = 0;
        chk("frame_done", 32'(oFrameDone), 1);
        step();
        chk("done_one_cycle", 32'(oFrameDone), 0);
        chk("back_idle", 32'(oBusy), 0);
`ifdef FRAME_CNT_EN
        chk("cnt_after_1", 32'(oFrameCnt), 1);
`else
        chk("cnt_after_1", 32'(oFrameCnt), 0);
`endif

        // Read request while idle: no BRAM access, sticky error, cleared by next load start.
        iRdCs = 1; #1;
        chk("idle_rd_memen", 32'(oMemEn), 0);
        step(); iRdCs = 0;
        chk("rd_err_set", 32'(oRdErr), 1);
        step();
        chk("rd_err_sticky", 32'(oRdErr), 1);
        iLoadStart = 1; step(); iLoadStart = 0;
        chk("rd_err_clear", 32'(oRdErr), 0);

        // Abort after 6 writes.
        for (int i = 0; i < 6; i++) begin iWrValid = 1; iWrData = DATA_W'($urandom); step(); end
        iWrValid = 0; iRst = 0; #1;
        chk("abort_busy", 32'(oBusy), 0);
        chk("abort_ready", 32'(oWrReady), 0);
        chk("abort_cnt", 32'(oFrameCnt), 0);
        step(); iRst = 1; step();

        // Restart loads from address 0, then three back-to-back frames.
        iLoadStart = 1; step(); iLoadStart = 0;
        iWrValid = 1; iWrData = 24'h0000AA; #1;
        chk("restart_addr", 32'(oMemAddr), 0);
        step();
        for (int i = 1; i < DEPTH; i++) begin iWrData = DATA_W'(32'hAA + i); step(); end
        iWrValid = 0; step();
        iWinValid = 1; step(); step(); iWinValid = 0; step();
        do_frame(32'h200);
        do_frame(32'h300);
`ifdef FRAME_CNT_EN
        chk("cnt_after_3", 32'(oFrameCnt), 3);
`else
        chk("cnt_after_3", 32'(oFrameCnt), 0);
`endif

        // Random traffic including occasional resets.
        repeat (800) begin
            iLoadStart = ($urandom_range(0, 9) == 0);
            iWrValid   = ($urandom_range(0, 9) < 7);
            iWrData    = DATA_W'($urandom);
            iRdCs      = ($urandom_range(0, 9) < 3);
            iRdAddr    = ADDR_W'($urandom_range(0, DEPTH - 1));
            iWinValid  = ($urandom_range(0, 9) < 3);
            iRst       = ($urandom_range(0, 99) != 0);
            step();
        end
        iRst = 1;
        idle_inputs();
        repeat (3) step();

        run_chk = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
